// File: rtl/alu_design_pkg.sv
// Shared definitions for the registered ALU: data width, command encodings,
// operand-valid encodings, the flag bundle and the operand-requirement decode.
package alu_design_pkg;

   localparam int DATA_WIDTH = 8;

   typedef enum logic [3:0] {
      A_ADD     = 4'd0,
      A_SUB     = 4'd1,
      A_ADD_CIN = 4'd2,
      A_SUB_CIN = 4'd3,
      A_INC_A   = 4'd4,
      A_DEC_A   = 4'd5,
      A_INC_B   = 4'd6,
      A_DEC_B   = 4'd7,
      A_CMP     = 4'd8,
      A_MUL_INC = 4'd9,
      A_MUL_SHL = 4'd10,
      A_SADD    = 4'd11,
      A_SSUB    = 4'd12
   } arith_cmd_e;

   typedef enum logic [3:0] {
      L_AND    = 4'd0,
      L_NAND   = 4'd1,
      L_OR     = 4'd2,
      L_NOR    = 4'd3,
      L_XOR    = 4'd4,
      L_XNOR   = 4'd5,
      L_NOT_A  = 4'd6,
      L_NOT_B  = 4'd7,
      L_SHR1_A = 4'd8,
      L_SHL1_A = 4'd9,
      L_SHR1_B = 4'd10,
      L_SHL1_B = 4'd11,
      L_ROL    = 4'd12,
      L_ROR    = 4'd13
   } logic_cmd_e;

   localparam logic [3:0] ARITH_LAST = 4'd12;
   localparam logic [3:0] LOGIC_LAST = 4'd13;

   localparam logic [1:0] IV_NONE = 2'b00;
   localparam logic [1:0] IV_A    = 2'b01;
   localparam logic [1:0] IV_B    = 2'b10;
   localparam logic [1:0] IV_AB   = 2'b11;

   typedef struct packed {
      logic cout;
      logic oflow;
      logic g;
      logic e;
      logic l;
      logic err;
   } alu_flags_t;

   // Which operands a command consumes; anything not single-operand needs both.
   function automatic logic [1:0] operand_need(input logic mode, input logic [3:0] cmd);
      logic [1:0] need;
      need = IV_AB;
      if (mode) begin
         if (cmd == A_INC_A || cmd == A_DEC_A)
            need = IV_A;
         else if (cmd == A_INC_B || cmd == A_DEC_B)
            need = IV_B;
      end else begin
         if (cmd == L_NOT_A || cmd == L_SHR1_A || cmd == L_SHL1_A)
            need = IV_A;
         else if (cmd == L_NOT_B || cmd == L_SHR1_B || cmd == L_SHL1_B)
            need = IV_B;
      end
      return need;
   endfunction

endpackage

// File: rtl/alu_design_mul.sv
// Second pipeline register: holds a computed result/flag bundle one extra cycle
// (multiplies, and any op queued behind one so ordering is preserved).
module alu_mul_stage
   import alu_design_pkg::*;
#(
   parameter int W = DATA_WIDTH
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           ce,
   input  logic           load,
   input  logic [2*W-1:0] res_in,
   input  alu_flags_t     flg_in,
   output logic [2*W-1:0] res_out,
   output alu_flags_t     flg_out,
   output logic           valid
);

   logic [2*W-1:0] res_reg;
   alu_flags_t     flg_reg;
   logic           valid_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_reg   <= '0;
         flg_reg   <= '0;
         valid_reg <= 1'b0;
      end else if (ce) begin
         valid_reg <= load;
         if (load) begin
            res_reg <= res_in;
            flg_reg <= flg_in;
         end
      end
   end

   assign res_out = res_reg;
   assign flg_out = flg_reg;
   assign valid   = valid_reg;

endmodule

// File: rtl/alu_design.sv
// Registered arithmetic/logic unit: combinational decode/compute feeding an
// output register, with multiplies taking one extra cycle through alu_mul_stage.
module alu_design
   import alu_design_pkg::*;
#(
   parameter int W = DATA_WIDTH
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           ce,
   input  logic           mode,
   input  logic           Cin,
   input  logic [W-1:0]   opa,
   input  logic [W-1:0]   opb,
   input  logic [1:0]     inp_valid,
   input  logic [3:0]     cmd,
   output logic [2*W-1:0] result,
   output logic           Cout,
   output logic           oflow,
   output logic           G,
   output logic           E,
   output logic           L,
   output logic           Err
);

   localparam int AW = $clog2(W);
   localparam logic [W:0]     ONE_X  = {{W{1'b0}}, 1'b1};
   localparam logic [2*W-1:0] ONE_2W = {{(2*W-1){1'b0}}, 1'b1};

   logic [W:0]        a_ext, b_ext, cin_ext, arith_w;
   logic signed [W:0] sa, sb, sres;
   logic [2*W-1:0]    a_wide, b_wide, rot_wide;
   logic [W-1:0]      logic_res;
   logic [AW-1:0]     rot_amt;
   logic [1:0]        need;
   logic              bad_cmd, bad_rot, missing;

   logic [2*W-1:0]    res_next;
   alu_flags_t        flg_next;
   logic              is_mul;

   logic [2*W-1:0]    result_reg;
   alu_flags_t        flg_reg;
   logic [2*W-1:0]    pipe_res;
   alu_flags_t        pipe_flg;
   logic              pipe_valid;

   assign a_ext   = {1'b0, opa};
   assign b_ext   = {1'b0, opb};
   assign cin_ext = {{W{1'b0}}, Cin};
   assign sa      = {opa[W-1], opa};
   assign sb      = {opb[W-1], opb};
   assign a_wide  = {{W{1'b0}}, opa};
   assign b_wide  = {{W{1'b0}}, opb};
   assign rot_amt = opb[AW-1:0];

   always_comb begin
      res_next  = '0;
      flg_next  = '0;
      is_mul    = 1'b0;
      arith_w   = '0;
      sres      = '0;
      logic_res = '0;
      rot_wide  = '0;

      need    = operand_need(mode, cmd);
      missing = (inp_valid & need) != need;
      bad_cmd = mode ? (cmd > ARITH_LAST) : (cmd > LOGIC_LAST);
      bad_rot = !mode && (cmd == L_ROL || cmd == L_ROR) && ((opb >> AW) != '0);

      if (missing || bad_cmd || bad_rot) begin
         flg_next.err = 1'b1;
      end else if (mode) begin
         case (cmd)
            A_ADD: begin
               arith_w       = a_ext + b_ext;
               flg_next.cout = arith_w[W];
            end
            A_SUB: begin
               arith_w        = a_ext - b_ext;
               flg_next.oflow = opa < opb;
            end
            A_ADD_CIN: begin
               arith_w       = a_ext + b_ext + cin_ext;
               flg_next.cout = arith_w[W];
            end
            A_SUB_CIN: begin
               arith_w        = a_ext - b_ext - cin_ext;
               flg_next.oflow = a_ext < (b_ext + cin_ext);
            end
            A_INC_A: arith_w = a_ext + ONE_X;
            A_DEC_A: arith_w = a_ext - ONE_X;
            A_INC_B: arith_w = b_ext + ONE_X;
            A_DEC_B: arith_w = b_ext - ONE_X;
            A_CMP: begin
               flg_next.g = opa > opb;
               flg_next.e = opa == opb;
               flg_next.l = opa < opb;
            end
            A_MUL_INC: begin
               res_next = (a_wide + ONE_2W) * (b_wide + ONE_2W);
               is_mul   = 1'b1;
            end
            A_MUL_SHL: begin
               res_next = (a_wide << 1) * b_wide;
               is_mul   = 1'b1;
            end
            A_SADD, A_SSUB: begin
               sres           = (cmd == A_SADD) ? (sa + sb) : (sa - sb);
               // The W+1-bit result is exact; it overflows W bits when its top two bits differ.
               flg_next.oflow = sres[W] ^ sres[W-1];
               flg_next.g     = $signed(opa) > $signed(opb);
               flg_next.e     = opa == opb;
               flg_next.l     = $signed(opa) < $signed(opb);
            end
            default: ;
         endcase
         if (cmd < A_CMP)
            res_next = {{(W-1){1'b0}}, arith_w};
         else if (cmd == A_SADD || cmd == A_SSUB)
            res_next = {{(W-1){sres[W]}}, sres};
      end else begin
         case (cmd)
            L_AND:    logic_res = opa & opb;
            L_NAND:   logic_res = ~(opa & opb);
            L_OR:     logic_res = opa | opb;
            L_NOR:    logic_res = ~(opa | opb);
            L_XOR:    logic_res = opa ^ opb;
            L_XNOR:   logic_res = ~(opa ^ opb);
            L_NOT_A:  logic_res = ~opa;
            L_NOT_B:  logic_res = ~opb;
            L_SHR1_A: logic_res = opa >> 1;
            L_SHL1_A: logic_res = opa << 1;
            L_SHR1_B: logic_res = opb >> 1;
            L_SHL1_B: logic_res = opb << 1;
            // Rotates shift a doubled copy so the wrapped bits fall into the kept half.
            L_ROL: begin
               rot_wide  = {opa, opa} << rot_amt;
               logic_res = rot_wide[2*W-1:W];
            end
            L_ROR: begin
               rot_wide  = {opa, opa} >> rot_amt;
               logic_res = rot_wide[W-1:0];
            end
            default: ;
         endcase
         res_next = {{W{1'b0}}, logic_res};
      end
   end

   // Once something occupies the second stage, later ops queue behind it to keep order.
   alu_mul_stage #(.W(W)) u_mul_stage (
      .clk     (clk),
      .rst     (rst),
      .ce      (ce),
      .load    (pipe_valid | is_mul),
      .res_in  (res_next),
      .flg_in  (flg_next),
      .res_out (pipe_res),
      .flg_out (pipe_flg),
      .valid   (pipe_valid)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_reg <= '0;
         flg_reg    <= '0;
      end else if (ce) begin
         if (pipe_valid) begin
            result_reg <= pipe_res;
            flg_reg    <= pipe_flg;
         end else if (is_mul) begin
            result_reg <= '0;
            flg_reg    <= '0;
         end else begin
            result_reg <= res_next;
            flg_reg    <= flg_next;
         end
      end
   end

   assign result = result_reg;
   assign Cout   = flg_reg.cout;
   assign oflow  = flg_reg.oflow;
   assign G      = flg_reg.g;
   assign E      = flg_reg.e;
   assign L      = flg_reg.l;
   assign Err    = flg_reg.err;

endmodule

// File: tb/tb_alu_design.sv
// Directed and randomized checks of alu_design (W=8) against an arithmetic
// reference model; flags are compared packed as {Cout,oflow,G,E,L,Err}.
module tb_alu_design;

   typedef struct packed {
      logic [15:0] res;
      logic [5:0]  flg;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, ce, mode, Cin;
   logic [7:0]  opa, opb;
   logic [1:0]  inp_valid;
   logic [3:0]  cmd;
   logic [15:0] result;
   logic        Cout, oflow, G, E, L, Err;

   int n_cmp  = 0;
   int n_fail = 0;
   int n_txn  = 0;

   alu_design #(.W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .mode      (mode),
      .Cin       (Cin),
      .opa       (opa),
      .opb       (opb),
      .inp_valid (inp_valid),
      .cmd       (cmd),
      .result    (result),
      .Cout      (Cout),
      .oflow     (oflow),
      .G         (G),
      .E         (E),
      .L         (L),
      .Err       (Err)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic m, input logic ci, input logic [7:0] a,
                                  input logic [7:0] b, input logic [1:0] iv, input logic [3:0] c);
      exp_t r;
      int ai, bi, sa, sb, s, n;
      logic [1:0] need;
      logic co, ov, g, e, l;
      r = '0; co = 0; ov = 0; g = 0; e = 0; l = 0; s = 0;
      ai = int'(a); bi = int'(b);
      sa = (ai > 127) ? ai - 256 : ai;
      sb = (bi > 127) ? bi - 256 : bi;
      if (m) need = (c == 4 || c == 5) ? 2'b01 : (c == 6 || c == 7) ? 2'b10 : 2'b11;
      else   need = (c == 6 || c == 8 || c == 9) ? 2'b01 : (c == 7 || c == 10 || c == 11) ? 2'b10 : 2'b11;
      if ((iv & need) != need || (m && c > 12) || (!m && c > 13) || (!m && (c == 12 || c == 13) && bi > 7)) begin
         r.flg = 6'b000001;
         return r;
      end
      if (m) begin
         case (c)
            0: begin s = ai + bi; co = s > 255; end
            1: begin s = (ai - bi) & 'h1FF; ov = ai < bi; end
            2: begin s = ai + bi + int'(ci); co = s > 255; end
            3: begin s = (ai - bi - int'(ci)) & 'h1FF; ov = ai < bi + int'(ci); end
            4: s = ai + 1;
            5: s = (ai - 1) & 'h1FF;
            6: s = bi + 1;
            7: s = (bi - 1) & 'h1FF;
            8: begin g = ai > bi; e = ai == bi; l = ai < bi; end
            9: s = ((ai + 1) * (bi + 1)) & 'hFFFF;
            10: s = (ai * 2 * bi) & 'hFFFF;
            default: begin
               s = (c == 11) ? sa + sb : sa - sb;
               ov = s > 127 || s < -128;
               g = sa > sb; e = sa == sb; l = sa < sb;
               s = s & 'hFFFF;
            end
         endcase
      end else begin
         n = bi;
         case (c)
            0: s = ai & bi;
            1: s = ~(ai & bi) & 'hFF;
            2: s = ai | bi;
            3: s = ~(ai | bi) & 'hFF;
            4: s = ai ^ bi;
            5: s = ~(ai ^ bi) & 'hFF;
            6: s = ~ai & 'hFF;
            7: s = ~bi & 'hFF;
            8: s = ai >> 1;
            9: s = (ai << 1) & 'hFF;
            10: s = bi >> 1;
            11: s = (bi << 1) & 'hFF;
            12: s = ((ai << n) | (ai >> (8 - n))) & 'hFF;
            default: s = ((ai >> n) | (ai << (8 - n))) & 'hFF;
         endcase
      end
      r.res = s[15:0];
      r.flg = {co, ov, g, e, l, 1'b0};
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [5:0] flags_now();
      return {Cout, oflow, G, E, L, Err};
   endfunction

   task automatic drive(input logic m, input logic ci, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] iv, input logic [3:0] c);
      mode = m; Cin = ci; opa = a; opb = b; inp_valid = iv; cmd = c;
   endtask

   // Called at a falling edge: hold inputs for two rising edges, sample on the next falling edge.
   task automatic do_op(input string tag, input logic m, input logic ci, input logic [7:0] a,
                        input logic [7:0] b, input logic [1:0] iv, input logic [3:0] c);
      exp_t ex;
      drive(m, ci, a, b, iv, c);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      ex = model(m, ci, a, b, iv, c);
      check({tag, "_result"}, 32'(result), 32'(ex.res));
      check({tag, "_flags"}, 32'(flags_now()), 32'(ex.flg));
      n_txn++;
      $display("txn %0d %s mode=%0d cmd=%0d a=%02h b=%02h cin=%0d iv=%b -> result=%04h flags=%b",
               n_txn, tag, m, c, a, b, ci, iv, result, flags_now());
   endtask

   initial begin
      exp_t ex1, ex2;
      logic       rm, rc;
      logic [7:0] ra, rb;
      logic [1:0] riv;
      logic [3:0] rcmd;

      rst = 1'b1; ce = 1'b1;
      drive(1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 4'd0);
      @(negedge clk);
      @(negedge clk);
      check("reset_result", 32'(result), 32'h0);
      check("reset_flags", 32'(flags_now()), 32'h0);
      rst = 1'b0;

      // Single-cycle latency for a non-multiply op from an idle pipeline.
      drive(1'b1, 1'b0, 8'hFF, 8'h01, 2'b11, 4'd0);
      @(posedge clk);
      #1;
      ex1 = model(1'b1, 1'b0, 8'hFF, 8'h01, 2'b11, 4'd0);
      check("lat1_result", 32'(result), 32'(ex1.res));
      check("lat1_flags", 32'(flags_now()), 32'(ex1.flg));
      @(negedge clk);

      // Asynchronous reset in the middle of an op, then hold after release.
      drive(1'b1, 1'b0, 8'h05, 8'h06, 2'b11, 4'd9);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst_result", 32'(result), 32'h0);
      check("async_rst_flags", 32'(flags_now()), 32'h0);
      @(negedge clk);
      rst = 1'b0; ce = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("post_rst_hold_result", 32'(result), 32'h0);
      check("post_rst_hold_flags", 32'(flags_now()), 32'h0);
      ce = 1'b1;

      do_op("add_ff_01", 1'b1, 1'b0, 8'hFF, 8'h01, 2'b11, 4'd0);
      do_op("sub_03_05", 1'b1, 1'b0, 8'h03, 8'h05, 2'b11, 4'd1);
      do_op("cmp_eq", 1'b1, 1'b0, 8'h05, 8'h05, 2'b11, 4'd8);
      do_op("cmp_gt", 1'b1, 1'b0, 8'h09, 8'h05, 2'b11, 4'd8);
      do_op("cmp_lt", 1'b1, 1'b0, 8'h02, 8'h05, 2'b11, 4'd8);
      do_op("mul_inc", 1'b1, 1'b0, 8'h02, 8'h03, 2'b11, 4'd9);
      do_op("mul_shl", 1'b1, 1'b0, 8'h03, 8'h04, 2'b11, 4'd10);
      do_op("rol_81", 1'b0, 1'b0, 8'h81, 8'h01, 2'b11, 4'd12);
      do_op("ror_01", 1'b0, 1'b0, 8'h01, 8'h01, 2'b11, 4'd13);
      do_op("ror_bad_amt", 1'b0, 1'b0, 8'h01, 8'h10, 2'b11, 4'd13);
      do_op("dec_a_zero", 1'b1, 1'b0, 8'h00, 8'h00, 2'b01, 4'd5);
      do_op("inc_b_ff", 1'b1, 1'b0, 8'h00, 8'hFF, 2'b10, 4'd6);
      do_op("sub_cin", 1'b1, 1'b1, 8'h05, 8'h05, 2'b11, 4'd3);
      do_op("sadd_ovf", 1'b1, 1'b0, 8'h7F, 8'h01, 2'b11, 4'd11);
      do_op("ssub_neg", 1'b1, 1'b0, 8'h80, 8'h01, 2'b11, 4'd12);
      do_op("arith_bad_cmd", 1'b1, 1'b0, 8'h12, 8'h34, 2'b11, 4'd13);
      do_op("logic_bad_cmd", 1'b0, 1'b0, 8'h12, 8'h34, 2'b11, 4'd14);
      do_op("iv_none", 1'b0, 1'b0, 8'h12, 8'h34, 2'b00, 4'd0);

      // A multiply followed at once by another op: both come out, in order.
      drive(1'b1, 1'b0, 8'h02, 8'h03, 2'b11, 4'd9);
      @(posedge clk);
      @(negedge clk);
      drive(1'b1, 1'b0, 8'h01, 8'h02, 2'b11, 4'd0);
      ex1 = model(1'b1, 1'b0, 8'h02, 8'h03, 2'b11, 4'd9);
      ex2 = model(1'b1, 1'b0, 8'h01, 8'h02, 2'b11, 4'd0);
      @(posedge clk);
      #1 check("order_mul_first", 32'(result), 32'(ex1.res));
      @(posedge clk);
      #1 check("order_next_op", 32'(result), 32'(ex2.res));
      @(negedge clk);

      // Missing operand, then ce=0 with new inputs: outputs must not move.
      do_op("add_iv01", 1'b1, 1'b0, 8'h10, 8'h20, 2'b01, 4'd0);
      ex1 = model(1'b1, 1'b0, 8'h10, 8'h20, 2'b01, 4'd0);
      ce = 1'b0;
      drive(1'b1, 1'b0, 8'h03, 8'h05, 2'b11, 4'd1);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("ce0_hold_result", 32'(result), 32'(ex1.res));
      check("ce0_hold_flags", 32'(flags_now()), 32'(ex1.flg));

      // A multiply frozen by ce=0 resumes and completes before the following op.
      ce = 1'b1;
      drive(1'b1, 1'b0, 8'h03, 8'h04, 2'b11, 4'd10);
      @(posedge clk);
      @(negedge clk);
      ce = 1'b0;
      drive(1'b1, 1'b0, 8'h07, 8'h07, 2'b11, 4'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("frozen_mul_pending", 32'(result), 32'h0);
      ce = 1'b1;
      ex1 = model(1'b1, 1'b0, 8'h03, 8'h04, 2'b11, 4'd10);
      ex2 = model(1'b1, 1'b0, 8'h07, 8'h07, 2'b11, 4'd0);
      @(posedge clk);
      #1 check("frozen_mul_done", 32'(result), 32'(ex1.res));
      @(posedge clk);
      #1 check("after_frozen_op", 32'(result), 32'(ex2.res));
      @(negedge clk);

      for (int i = 0; i < 150; i++) begin
         rm   = 1'($urandom_range(0, 1));
         rc   = 1'($urandom_range(0, 1));
         ra   = 8'($urandom);
         rb   = 8'($urandom);
         rcmd = 4'($urandom_range(0, 15));
         riv  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
         if (!rm && (rcmd == 4'd12 || rcmd == 4'd13) && $urandom_range(0, 3) != 0)
            rb = 8'($urandom_range(0, 7));
         do_op("rand", rm, rc, ra, rb, riv, rcmd);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
